// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: sequential unsigned restoring divider.
// Resolves one quotient bit per clock under a start/busy/done handshake.
// A zero divisor skips the iterations. It returns an all-ones quotient, the
// dividend as remainder, and sets div_by_zero.
module seq_divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dq;       // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dv;       // latched divisor
  logic [WIDTH:0]   pr;       // partial remainder
  logic [CNT_W-1:0] cnt;      // completed iterations
  logic             zero;     // current op has a zero divisor

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // Trial subtraction for one restoring step; the top bit of the
  // widened difference is the borrow.
  always_comb begin
    shifted = {pr[WIDTH-1:0], dq[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dv};
    borrow  = trial[WIDTH+1];
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dq          <= '0;
      dv          <= '0;
      pr          <= '0;
      cnt         <= '0;
      zero        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dq    <= dividend;
            dv    <= divisor;
            pr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            zero  <= (divisor == '0);
            state <= (divisor == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          pr  <= borrow ? shifted : trial[WIDTH:0];
          dq  <= {dq[WIDTH-2:0], ~borrow};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            state <= FIN;
          end
        end
        FIN: begin
          // On a zero divisor dq still holds the untouched dividend.
          quotient    <= zero ? '1 : dq;
          remainder   <= zero ? dq : pr[WIDTH-1:0];
          div_by_zero <= zero;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb_seq_divider_16bit: directed and random checks of seq_divider_16bit
// against an arithmetic reference model (integer / and %).
module tb_seq_divider_16bit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider_16bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           e0;
  } op_t;

  op_t          pend[$];
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;
  logic         held_z = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Compare process: every falling edge, outputs against the model.
  op_t          op;
  logic [W-1:0] eq, er;
  logic         ez;
  int           lat;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end else if (done) begin
      if (pend.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        op = pend.pop_front();
        if (op.b == '0) begin
          eq = '1; er = op.a; ez = 1'b1;
        end else begin
          eq = op.a / op.b; er = op.a % op.b; ez = 1'b0;
        end
        lat = cyc - op.e0;
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(ez));
        chk("busy_in_done", 32'(busy), 32'd0);
        if (op.b == '0) begin
          chk("latency_zero_div", 32'(lat >= 1 && lat <= 2), 32'd1);
        end else begin
          chk("latency", 32'(lat), 32'd17);
          chk("invariant", 32'(quotient) * 32'(op.b) + 32'(remainder), 32'(op.a));
          chk("rem_lt_div", 32'(remainder < op.b), 32'd1);
        end
        held_q = eq; held_r = er; held_z = ez;
      end
    end else begin
      chk("hold_quotient", 32'(quotient), 32'(held_q));
      chk("hold_remainder", 32'(remainder), 32'(held_r));
      chk("hold_dbz", 32'(div_by_zero), 32'(held_z));
      chk("busy", 32'(busy), 32'(pend.size() > 0 && cyc >= pend[0].e0));
    end
  end

  // Presents an op at a falling edge; the next rising edge is E0.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    op_t o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    o.a = a; o.b = b; o.e0 = cyc + 1;
    pend.push_back(o);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic lit(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    chk("lit_quotient", 32'(quotient), 32'(q));
    chk("lit_remainder", 32'(remainder), 32'(r));
    chk("lit_dbz", 32'(div_by_zero), 32'(z));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    lit(16'h0000, 16'h0000, 1'b0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 100 / 7
    issue(16'd100, 16'd7);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done();
    lit(16'd14, 16'd2, 1'b0);

    // Extremes and dividend < divisor, back-to-back from the done cycle
    issue(16'hFFFF, 16'd1);     wait_done(); lit(16'hFFFF, 16'd0, 1'b0);
    issue(16'hFFFF, 16'hFFFF);  wait_done(); lit(16'd1, 16'd0, 1'b0);
    issue(16'd3, 16'd10);       wait_done(); lit(16'd0, 16'd3, 1'b0);

    // Divide by zero, then the flag clears on the next op
    issue(16'd5, 16'd0);        wait_done(); lit(16'hFFFF, 16'd5, 1'b1);
    issue(16'd9, 16'd3);        wait_done(); lit(16'd3, 16'd0, 1'b0);

    // Start while busy is ignored (sampled at E0+5)
    issue(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    dividend = 16'd8;
    divisor  = 16'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    lit(16'd14, 16'd2, 1'b0);
    repeat (25) @(negedge clk);
    chk("no_extra_done", 32'(pend.size()), 32'd0);

    // Reset mid-op at E0+8
    issue(16'd100, 16'd7);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pend.delete();
    held_q = '0; held_r = '0; held_z = 1'b0;
    #1;
    lit(16'd0, 16'd0, 1'b0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(16'd40, 16'd6);
    wait_done();
    lit(16'd6, 16'd4, 1'b0);

    // Back-to-back random pairs
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      issue(ra, rb);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(pend.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
